piso_tx: RTL and testbench
==========================

PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, giving the parallel word width in bits (legal range 2..32).
REQ-002 SHALL provide parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
REQ-003 SHALL provide parameter IDLE_LEVEL, default 0, giving the serial_out level whenever no word is being shifted.
REQ-004 SHALL provide port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL provide port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL provide port parallel_in, input, WIDTH bits: the word to serialize, sampled only on accept.
REQ-007 SHALL provide port load_valid, input, 1 bit: a word is offered on parallel_in.
REQ-008 SHALL provide port load_ready, output, 1 bit: the block can accept a word this cycle.
REQ-009 SHALL provide port shift_en, input, 1 bit: advance one bit this cycle; 0 = hold.
REQ-010 SHALL provide port abort, input, 1 bit: synchronous cancel of the current word.
REQ-011 SHALL provide port serial_out, output, 1 bit: the current serial bit.
REQ-012 SHALL provide port serial_valid, output, 1 bit: serial_out carries a data bit.
REQ-013 SHALL provide port busy, output, 1 bit: a word is loaded and not yet fully shifted.
REQ-014 SHALL provide port done, output, 1 bit: one-cycle pulse after the last bit of a word completes.

Function
REQ-015 SHALL implement a two-state FSM (IDLE, SHIFT), a WIDTH-bit shift register and a bit counter of clog2(WIDTH) bits.
REQ-016 SHALL drive load_ready combinationally: 1 in IDLE; 1 in SHIFT only when counter = WIDTH-1 and shift_en = 1 and abort = 0; otherwise 0.
REQ-017 SHALL treat accept as load_valid & load_ready at a rising edge; on accept, capture parallel_in, clear the counter and enter or stay in SHIFT.
REQ-018 SHALL drive serial_valid = busy = 1 exactly while in SHIFT.
REQ-019 SHALL drive serial_out as the next-to-send bit while in SHIFT, and as IDLE_LEVEL in IDLE; both cases are decoded from registers only.
REQ-020 SHALL present the first bit of a word in the cycle after accept, with zero extra latency.
REQ-021 SHALL, in SHIFT with shift_en = 1, count the current bit as sent at the edge, then shift the register toward the output end and increment the counter.
REQ-022 SHALL, in SHIFT with shift_en = 0, hold the register, counter and serial_out unchanged for any number of cycles.
REQ-023 SHALL, at the edge where counter = WIDTH-1 and shift_en = 1, enter IDLE if no accept occurs, or reload the new word and stay in SHIFT (gapless back-to-back stream).
REQ-024 SHALL assert done for exactly one cycle after each edge that completes the last bit, including back-to-back reloads.
REQ-025 SHALL make abort = 1 highest priority: go to IDLE at the next edge, with no done, no accept (load_ready = 0) and the shift register cleared; in IDLE, abort has no effect.
REQ-026 SHALL ignore parallel_in and load_valid whenever load_ready = 0, and SHALL NOT corrupt the word in flight.
REQ-027 SHALL keep the counter within 0..WIDTH-1 and never wrap it silently; it restarts at 0 only on accept.

Reset
REQ-028 SHALL, while reset = 1, immediately force state IDLE, shift register 0, counter 0, done 0, busy 0, serial_valid 0, serial_out IDLE_LEVEL and load_ready 1.
REQ-029 SHALL discard any word in flight when reset is asserted mid-word, with no done pulse.
REQ-030 SHALL accept a load on the first rising edge after reset deassertion.

Verification
REQ-031 SHALL verify basic MSB-first send: WIDTH=8, load 8'hB2, shift_en held 1 -> serial_out over 8 cycles = 1,0,1,1,0,0,1,0; done pulses in the 9th cycle; then IDLE with serial_out = 0.
REQ-032 SHALL verify LSB-first send: MSB_FIRST=0, load 8'hB2 -> sequence 0,1,0,0,1,1,0,1.
REQ-033 SHALL verify back-to-back loads: 8'hB2 then 8'h5A offered at counter = 7 -> 16 contiguous valid bits, no idle gap, two done pulses 8 cycles apart.
REQ-034 SHALL verify stalls: shift_en toggled 1,0,0,1,... during 8'hFF -> each bit held across stall cycles; exactly 8 enabled cycles sent; load_ready stays 0 until the last bit.
REQ-035 SHALL verify abort: abort at bit 3 of 8'hB2 with load_valid = 1 -> IDLE next cycle, no done, no accept that cycle; the next word is accepted one cycle later.
REQ-036 SHALL verify reset mid-word: reset asserted asynchronously at bit 4 -> outputs reach reset values before the next edge; no done; a fresh 8'h81 after release sends 1,0,0,0,0,0,0,1.

Source files
------------

// File: rtl/piso_tx.sv
// -----------------------------------------------------------------------------
// piso_tx : parallel-in / serial-out transmitter.
//
// A word offered on parallel_in is captured when load_valid & load_ready and
// then presented one bit per enabled cycle on serial_out (MSB or LSB first).
// The word after it can be loaded on the same edge that retires the last bit,
// so a stream of words leaves with no idle gap between them.
//
// Parameters
//   WIDTH       parallel word width (2..32)
//   MSB_FIRST   1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//   IDLE_LEVEL  serial_out level while no word is being shifted
//
// Ports
//   clk           clock, rising edge
//   reset         asynchronous active-high reset
//   parallel_in   word to send, sampled only on accept
//   load_valid    a word is offered
//   load_ready    block can take a word this cycle (combinational)
//   shift_en      advance one bit this cycle, 0 = hold
//   abort         cancel the word in flight
//   serial_out    current serial bit
//   serial_valid  serial_out carries a data bit
//   busy          a word is loaded and not fully shifted
//   done          one-cycle pulse after the last bit of a word completes
// -----------------------------------------------------------------------------
module piso_tx #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  input  logic             abort,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned     CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sreg_q;
  logic [CW-1:0]    cnt_q;
  logic             done_q;

  logic             last_bit;
  logic             accept;
  logic [WIDTH-1:0] sreg_shifted;

  // The last bit retires this edge; this is the only point in SHIFT where a
  // new word may be taken, which is what makes back-to-back words gapless.
  assign last_bit   = (state_q == SHIFT) && (cnt_q == LAST) && shift_en && !abort;
  assign load_ready = (state_q == IDLE) || last_bit;
  assign accept     = load_valid && load_ready;

  // Move the register toward the output end so the next bit is always at the
  // same tap.
  assign sreg_shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                                  : {1'b0, sreg_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= last_bit;
      case (state_q)
        IDLE: begin
          // abort has no meaning here, so a load is still taken
          if (accept) begin
            sreg_q  <= parallel_in;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (abort) begin
            state_q <= IDLE;
            sreg_q  <= '0;
          end else if (shift_en) begin
            if (cnt_q == LAST) begin
              if (accept) begin
                sreg_q <= parallel_in;
                cnt_q  <= '0;
              end else begin
                // counter parks at LAST; it only restarts on the next accept
                state_q <= IDLE;
                sreg_q  <= '0;
              end
            end else begin
              sreg_q <= sreg_shifted;
              cnt_q  <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode from registers only.
  assign busy         = (state_q == SHIFT);
  assign serial_valid = (state_q == SHIFT);
  assign serial_out   = (state_q == SHIFT) ? (MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0])
                                           : IDLE_LEVEL;
  assign done         = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: two instances (MSB-first idle-low, LSB-first idle-high)
// driven by the same inputs and compared every cycle against a word/bit-index
// model, plus directed sequences with literal expected bit streams.
module tb_piso_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pin = 8'h00;
  logic       lv = 1'b0, se = 1'b0, ab = 1'b0;

  logic lr_m, so_m, sv_m, bz_m, dn_m;
  logic lr_l, so_l, sv_l, bz_l, dn_l;

  int checks = 0;
  int errors = 0;

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
    .clk(clk), .reset(reset), .parallel_in(pin), .load_valid(lv),
    .load_ready(lr_m), .shift_en(se), .abort(ab), .serial_out(so_m),
    .serial_valid(sv_m), .busy(bz_m), .done(dn_m));

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb (
    .clk(clk), .reset(reset), .parallel_in(pin), .load_valid(lv),
    .load_ready(lr_l), .shift_en(se), .abort(ab), .serial_out(so_l),
    .serial_valid(sv_l), .busy(bz_l), .done(dn_l));

  initial forever #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare -------------------
  // A word in flight is just (word, number of bits already sent).
  bit         act_e  = 1'b0;
  int         sent   = 0;
  logic [7:0] word   = 8'h00;
  bit         done_e = 1'b0;

  always @(negedge clk) begin : cmp
    bit rdy, acc, dn_n, so_me, so_le;
    if (reset) begin
      act_e  = 1'b0;
      done_e = 1'b0;
    end
    rdy   = !act_e || (sent == 7 && se && !ab);
    so_me = act_e ? word[7-sent] : 1'b0;
    so_le = act_e ? word[sent]   : 1'b1;
    chk("msb_outputs{ready,out,valid,busy,done}",
        32'({lr_m, so_m, sv_m, bz_m, dn_m}), 32'({rdy, so_me, act_e, act_e, done_e}));
    chk("lsb_outputs{ready,out,valid,busy,done}",
        32'({lr_l, so_l, sv_l, bz_l, dn_l}), 32'({rdy, so_le, act_e, act_e, done_e}));
    if (!reset) begin
      acc  = lv && rdy;
      dn_n = act_e && sent == 7 && se && !ab;
      if (act_e && ab) act_e = 1'b0;
      else if (act_e && se) begin
        sent++;
        if (sent == 8) act_e = 1'b0;
      end
      if (acc) begin
        act_e = 1'b1;
        sent  = 0;
        word  = pin;
      end
      done_e = dn_n;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed + random stimulus ------------------------------
  initial begin : main
    logic [7:0]  vm, vl;
    logic [15:0] v16;
    int dcnt, nvalid, nen, rbad, dother;
    bit d9, d17, v17, d23, b23;

    #1;
    chk("reset_state{ready,busy,valid,out_m,done,out_l}",
        32'({lr_m, bz_m, sv_m, so_m, dn_m, so_l}), 32'(6'b100001));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // basic send, both bit orders
    pin = 8'hB2; lv = 1'b1; se = 1'b1; tick(); lv = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      #3; vm[7-i] = so_m; vl[i] = so_l; if (dn_m) dcnt++;
      tick();
    end
    #3;
    chk("msb_first_seq_B2", 32'(vm), 32'(8'hB2));
    chk("lsb_first_seq_B2", 32'(vl), 32'(8'hB2));
    chk("no_done_during_word", 32'(dcnt), 32'(0));
    chk("done_9th_cycle", 32'(dn_m), 32'(1));
    chk("idle_out_after_word", 32'({so_m, bz_m}), 32'(2'b00));
    tick();
    #3 chk("done_single_cycle", 32'(dn_m), 32'(0));
    tick();

    // back-to-back B2 then 5A
    pin = 8'hB2; lv = 1'b1; tick(); lv = 1'b0;
    nvalid = 0; dother = 0; d9 = 0; d17 = 0; v17 = 0; v16 = '0;
    for (int c = 1; c <= 17; c++) begin
      lv = (c == 8); pin = 8'h5A;
      #3;
      if (c <= 16) begin v16[16-c] = so_m; if (sv_m) nvalid++; end
      else v17 = sv_m;
      if (dn_m) begin
        if (c == 9) d9 = 1; else if (c == 17) d17 = 1; else dother++;
      end
      if (c == 8) chk("b2b_ready_at_last_bit", 32'(lr_m), 32'(1));
      tick();
    end
    lv = 1'b0;
    chk("b2b_stream", 32'(v16), 32'(16'hB25A));
    chk("b2b_valid_count", 32'(nvalid), 32'(16));
    chk("b2b_done_pulses", 32'({d9, d17}), 32'(2'b11));
    chk("b2b_stray_done", 32'(dother), 32'(0));
    chk("b2b_idle_after", 32'(v17), 32'(0));

    // stalls during FF
    pin = 8'hFF; lv = 1'b1; se = 1'b1; tick(); lv = 1'b0;
    nen = 0; rbad = 0; d23 = 0; b23 = 1;
    for (int c = 1; c <= 23; c++) begin
      se = (c % 3 == 1);
      #3;
      if (c <= 22) begin
        if (bz_m && se) nen++;
        if (lr_m != (c == 22)) rbad++;
        if (so_m != 1'b1) rbad++;
      end else begin
        d23 = dn_m; b23 = bz_m;
      end
      tick();
    end
    se = 1'b1;
    chk("stall_enabled_bits", 32'(nen), 32'(8));
    chk("stall_ready_and_hold_errs", 32'(rbad), 32'(0));
    chk("stall_done_busy", 32'({d23, b23}), 32'(2'b10));

    // abort at bit 3 with a load pending
    pin = 8'hB2; lv = 1'b1; tick(); lv = 1'b0;
    repeat (3) tick();
    ab = 1'b1; lv = 1'b1; pin = 8'h5A;
    #3 chk("abort_blocks_ready", 32'({lr_m, bz_m}), 32'(2'b01));
    tick();
    ab = 1'b0;
    #3 chk("abort_idle{busy,done,ready,out}", 32'({bz_m, dn_m, lr_m, so_m}), 32'(4'b0010));
    tick();
    lv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #3; vm[7-i] = so_m;
      tick();
    end
    chk("word_after_abort", 32'(vm), 32'(8'h5A));
    tick();

    // asynchronous reset at bit 4
    pin = 8'hB2; lv = 1'b1; tick(); lv = 1'b0;
    repeat (4) tick();
    #1 reset = 1'b1;
    #1 chk("async_reset_outputs", 32'({lr_m, bz_m, sv_m, so_m, dn_m, so_l}), 32'(6'b100001));
    tick();
    reset = 1'b0; lv = 1'b1; pin = 8'h81;
    #3 chk("no_done_after_reset", 32'(dn_m), 32'(0));
    tick(); lv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #3; vm[7-i] = so_m;
      tick();
    end
    chk("word_after_reset", 32'(vm), 32'(8'h81));
    tick();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 149) == 0);
      lv    = $urandom_range(0, 1) == 1;
      se    = ($urandom_range(0, 3) != 0);
      ab    = ($urandom_range(0, 19) == 0);
      pin   = 8'($urandom);
      tick();
    end
    reset = 1'b0; lv = 1'b0; ab = 1'b0; se = 1'b1;
    repeat (12) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
